// File: rtl/ioq_dst_demux_pkg.sv
// rtl/ioq_dst_demux_pkg.sv - shared constants and state encoding for the IOQ destination demux
package ioq_dst_demux_pkg;

    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;
    localparam int         IOQ_DST_PORT_POS   = 16;

    typedef enum logic [3:0] {
        WAIT_HDR  = 4'b0001,
        SEND_HDRS = 4'b0010,
        SEND_DATA = 4'b0100,
        DROP      = 4'b1000
    } state_t;

endpackage

// File: rtl/small_fifo.sv
// rtl/small_fifo.sv - fall-through input buffer with nearly-full flag
module small_fifo #(
    parameter int WIDTH             = 72,
    parameter int MAX_DEPTH_BITS    = 4,
    parameter int NEARLY_FULL_SLACK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      do_wr;
    logic                      do_rd;

    // The slack covers the registered in_rdy plus the writes already in flight upstream.
    assign full        = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(DEPTH - NEARLY_FULL_SLACK));
    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign dout        = mem[rd_ptr];

    // Storage array; contents are qualified by the pointers so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            depth <= depth + (MAX_DEPTH_BITS+1)'(do_wr) - (MAX_DEPTH_BITS+1)'(do_rd);
        end
    end

endmodule

// File: rtl/ioq_dst_demux.sv
// rtl/ioq_dst_demux.sv - forwards each packet to the ports named in its IOQ header bitmap
module ioq_dst_demux
    import ioq_dst_demux_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH/8,
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int FIFO_DEPTH_BITS   = 4,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic [NUM_OUTPUT_QUEUES-1:0] out_wr,
    input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
    output logic [CNT_WIDTH-1:0]         pkt_fwd_cnt,
    output logic [CNT_WIDTH-1:0]         pkt_drop_cnt,
    output logic [CNT_WIDTH-1:0]         hdr_err_cnt
);

    localparam int FIFO_WIDTH = DATA_WIDTH + CTRL_WIDTH;

    logic [FIFO_WIDTH-1:0]        fifo_dout;
    logic                         fifo_empty;
    logic                         fifo_nearly_full;
    logic                         fifo_rd;
    logic [DATA_WIDTH-1:0]        head_data;
    logic [CTRL_WIDTH-1:0]        head_ctrl;
    logic [NUM_OUTPUT_QUEUES-1:0] head_bitmap;
    logic                         head_is_ioq;
    logic                         head_is_data;

    state_t                       state;
    state_t                       state_nxt;
    logic [NUM_OUTPUT_QUEUES-1:0] dst_sel;
    logic [NUM_OUTPUT_QUEUES-1:0] dst_sel_nxt;
    logic                         drop_body;
    logic                         drop_body_nxt;
    logic                         ports_rdy;
    logic                         xfer;
    logic                         fwd_inc;
    logic                         drop_inc;
    logic                         hdr_inc;

    small_fifo #(
        .WIDTH          (FIFO_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign {head_ctrl, head_data} = fifo_dout;
    assign head_bitmap  = head_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];
    assign head_is_ioq  = (head_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
    assign head_is_data = (head_ctrl == '0);
    // Multicast is all-or-nothing: every selected port must be ready at once.
    assign ports_rdy    = ((out_rdy & dst_sel) == dst_sel);

    // Next-state, FIFO pop and counter-increment decisions.
    always_comb begin
        state_nxt     = state;
        dst_sel_nxt   = dst_sel;
        drop_body_nxt = drop_body;
        fifo_rd       = 1'b0;
        xfer          = 1'b0;
        fwd_inc       = 1'b0;
        drop_inc      = 1'b0;
        hdr_inc       = 1'b0;
        case (state)
            WAIT_HDR: begin
                if (!fifo_empty) begin
                    if (!head_is_ioq) begin
                        hdr_inc       = 1'b1;
                        drop_body_nxt = 1'b0;
                        state_nxt     = DROP;
                    end else if (head_bitmap == '0) begin
                        drop_inc      = 1'b1;
                        drop_body_nxt = 1'b0;
                        state_nxt     = DROP;
                    end else begin
                        dst_sel_nxt = head_bitmap;
                        state_nxt   = SEND_HDRS;
                    end
                end
            end
            SEND_HDRS: begin
                if (!fifo_empty && ports_rdy) begin
                    fifo_rd = 1'b1;
                    xfer    = 1'b1;
                    if (head_is_data) begin
                        state_nxt = SEND_DATA;
                    end
                end
            end
            SEND_DATA: begin
                if (!fifo_empty && ports_rdy) begin
                    fifo_rd = 1'b1;
                    xfer    = 1'b1;
                    if (!head_is_data) begin
                        fwd_inc     = 1'b1;
                        dst_sel_nxt = '0;
                        state_nxt   = WAIT_HDR;
                    end
                end
            end
            DROP: begin
                // Header words may carry any non-zero ctrl; the first non-zero ctrl after body words is EOP.
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    if (!drop_body) begin
                        if (head_is_data) begin
                            drop_body_nxt = 1'b1;
                        end
                    end else if (!head_is_data) begin
                        drop_body_nxt = 1'b0;
                        state_nxt     = WAIT_HDR;
                    end
                end
            end
            default: begin
                dst_sel_nxt   = '0;
                drop_body_nxt = 1'b0;
                state_nxt     = WAIT_HDR;
            end
        endcase
    end

    // State, destination selection and drop-phase tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_HDR;
            dst_sel   <= '0;
            drop_body <= 1'b0;
        end else begin
            state     <= state_nxt;
            dst_sel   <= dst_sel_nxt;
            drop_body <= drop_body_nxt;
        end
    end

    // Shared output register; the write strobe follows the decision cycle by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_wr   <= '0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= xfer ? dst_sel : '0;
            if (xfer) begin
                out_data <= head_data;
                out_ctrl <= head_ctrl;
            end
        end
    end

    // Statistics counters, wrapping naturally, plus registered input ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_fwd_cnt  <= '0;
            pkt_drop_cnt <= '0;
            hdr_err_cnt  <= '0;
            in_rdy       <= 1'b0;
        end else begin
            pkt_fwd_cnt  <= pkt_fwd_cnt + CNT_WIDTH'(fwd_inc);
            pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(drop_inc);
            hdr_err_cnt  <= hdr_err_cnt + CNT_WIDTH'(hdr_inc);
            in_rdy       <= !fifo_nearly_full;
        end
    end

endmodule

// File: tb/tb_ioq_dst_demux.sv
// tb/tb_ioq_dst_demux.sv - self-checking bench for ioq_dst_demux
module tb_ioq_dst_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [7:0]  out_wr;
    logic [7:0]  out_rdy;
    logic [31:0] pkt_fwd_cnt;
    logic [31:0] pkt_drop_cnt;
    logic [31:0] hdr_err_cnt;

    ioq_dst_demux dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_wr        (in_wr),
        .in_rdy       (in_rdy),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .out_wr       (out_wr),
        .out_rdy      (out_rdy),
        .pkt_fwd_cnt  (pkt_fwd_cnt),
        .pkt_drop_cnt (pkt_drop_cnt),
        .hdr_err_cnt  (hdr_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mask;
        logic [7:0]  ctrl;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pkt_c[$];
    logic [63:0] pkt_d[$];
    int          checks = 0;
    int          errors = 0;
    int          m_fwd = 0;
    int          m_drop = 0;
    int          m_hdr = 0;
    int          wr_count = 0;
    logic [7:0]  pkt_id = 8'h00;
    logic [7:0]  prev_rdy = 8'h00;
    bit          saw_in_rdy_low = 0;
    bit          toggle_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready as seen by the DUT's decision at each rising edge.
    always @(posedge clk) prev_rdy <= out_rdy;

    // Every write must match the next expected word, only to ports that were all ready.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("wr_during_reset", out_wr, 0);
        end else begin
            if (!in_rdy) saw_in_rdy_low = 1;
            if (out_wr != 0) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", out_wr, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_mask", out_wr, e.mask);
                    chk("wr_data", out_data, e.data);
                    chk("wr_ctrl", out_ctrl, e.ctrl);
                    chk("wr_ports_ready", prev_rdy & out_wr, out_wr);
                end
            end
        end
    end

    task automatic build_pkt(input logic [7:0] bm, input logic [7:0] first_ctrl,
                             input int n_hdr, input int n_data, input logic [7:0] eop_ctrl);
        pkt_c.delete();
        pkt_d.delete();
        pkt_c.push_back(first_ctrl);
        pkt_d.push_back({8'hC0, pkt_id, 16'h0000, 8'h00, bm, 16'h1234});
        for (int i = 1; i < n_hdr; i++) begin
            pkt_c.push_back(8'hFF);
            pkt_d.push_back({8'hE0, pkt_id, 16'(i), 32'h5A5A_5A5A});
        end
        for (int i = 0; i < n_data; i++) begin
            pkt_c.push_back(8'h00);
            pkt_d.push_back({8'hD0, pkt_id, 16'(i), 32'($urandom())});
        end
        pkt_c.push_back(eop_ctrl);
        pkt_d.push_back({8'hEE, pkt_id, 48'h0});
        pkt_id++;
    endtask

    // Model decides the fate of the whole packet, then the words are driven respecting in_rdy.
    task automatic send_pkt();
        logic [7:0] bm;
        exp_t       e;
        bm = pkt_d[0][23:16];
        if (pkt_c[0] != 8'hFF) m_hdr++;
        else if (bm == 0) m_drop++;
        else begin
            m_fwd++;
            for (int i = 0; i < pkt_c.size(); i++) begin
                e.mask = bm;
                e.ctrl = pkt_c[i];
                e.data = pkt_d[i];
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < pkt_c.size(); i++) begin
            int t = 0;
            while (!in_rdy && t < 1000) begin
                in_wr = 1'b0;
                @(negedge clk);
                t++;
            end
            if (t >= 1000) chk("in_rdy_timeout", t, 0);
            in_ctrl = pkt_c[i];
            in_data = pkt_d[i];
            in_wr   = 1'b1;
            @(negedge clk);
        end
        in_wr = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("drain_timeout", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_fwd_model"}, pkt_fwd_cnt, m_fwd);
        chk({tag, "_drop_model"}, pkt_drop_cnt, m_drop);
        chk({tag, "_hdr_model"}, hdr_err_cnt, m_hdr);
    endtask

    initial begin
        int base;
        int stall_wr;
        int t;
        reset   = 1'b1;
        in_wr   = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_rdy = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_out_wr", out_wr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_fwd", pkt_fwd_cnt, 0);
        chk("rst_drop", pkt_drop_cnt, 0);
        chk("rst_hdr", hdr_err_cnt, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("in_rdy_after_reset", in_rdy, 1);

        // Unicast: two IOQ-ctrl headers, 6 data words, EOP.
        out_rdy = 8'hFF;
        base = wr_count;
        build_pkt(8'b0000_0100, 8'hFF, 2, 6, 8'h04);
        send_pkt();
        wait_drain();
        chk("uni_writes", wr_count - base, 9);
        chk("uni_fwd", pkt_fwd_cnt, 1);
        check_counters("uni");

        // Multicast with port 6 stalled mid-packet.
        base = wr_count;
        stall_wr = 0;
        build_pkt(8'b0101_0001, 8'hFF, 1, 10, 8'h01);
        fork
            send_pkt();
            begin
                repeat (6) @(negedge clk);
                out_rdy[6] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    if (out_wr != 0) stall_wr++;
                end
                out_rdy[6] = 1'b1;
            end
        join
        wait_drain();
        chk("mc_stall_writes", stall_wr, 0);
        chk("mc_writes", wr_count - base, 12);
        chk("mc_fwd", pkt_fwd_cnt, 2);
        check_counters("mc");

        // Zero bitmap packet followed by unicast to port 1.
        base = wr_count;
        build_pkt(8'h00, 8'hFF, 1, 8, 8'h08);
        send_pkt();
        build_pkt(8'b0000_0010, 8'hFF, 1, 3, 8'h02);
        send_pkt();
        wait_drain();
        chk("zero_drop", pkt_drop_cnt, 1);
        chk("zero_writes", wr_count - base, 5);
        chk("zero_fwd", pkt_fwd_cnt, 3);
        check_counters("zero");

        // Missing IOQ header, then a clean packet proves the FSM recovered.
        base = wr_count;
        build_pkt(8'b1000_0000, 8'h02, 1, 4, 8'h10);
        send_pkt();
        build_pkt(8'b1000_0000, 8'hFF, 1, 2, 8'h80);
        send_pkt();
        wait_drain();
        chk("hdr_err", hdr_err_cnt, 1);
        chk("hdr_writes", wr_count - base, 4);
        chk("hdr_fwd", pkt_fwd_cnt, 4);
        check_counters("hdr");

        // Back-to-back packets with ready toggling every cycle.
        saw_in_rdy_low = 0;
        toggle_en = 1;
        fork
            begin
                while (toggle_en) begin
                    @(negedge clk);
                    out_rdy = (out_rdy == 8'hFF) ? 8'h00 : 8'hFF;
                end
            end
        join_none
        base = wr_count;
        build_pkt(8'b0000_0001, 8'hFF, 1, 12, 8'h01);
        send_pkt();
        build_pkt(8'b0011_0000, 8'hFF, 2, 10, 8'h02);
        send_pkt();
        build_pkt(8'b1111_1111, 8'hFF, 1, 14, 8'h40);
        send_pkt();
        build_pkt(8'b0000_1000, 8'hFF, 1, 11, 8'h08);
        send_pkt();
        wait_drain();
        toggle_en = 0;
        repeat (2) @(negedge clk);
        out_rdy = 8'hFF;
        chk("b2b_in_rdy_low_seen", saw_in_rdy_low, 1);
        chk("b2b_writes", wr_count - base, 56);
        chk("b2b_fwd", pkt_fwd_cnt, 8);
        check_counters("b2b");

        // Reset after three words of a packet have gone out.
        out_rdy = 8'h00;
        build_pkt(8'b0000_1000, 8'hFF, 1, 8, 8'h08);
        send_pkt();
        base = wr_count;
        out_rdy = 8'hFF;
        t = 0;
        while (wr_count - base < 3 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("rst_mid_seen3", wr_count - base, 3);
        reset = 1'b1;
        #1;
        chk("rst_mid_out_wr", out_wr, 0);
        chk("rst_mid_out_data", out_data, 0);
        chk("rst_mid_fwd", pkt_fwd_cnt, 0);
        chk("rst_mid_drop", pkt_drop_cnt, 0);
        chk("rst_mid_hdr", hdr_err_cnt, 0);
        exp_q.delete();
        m_fwd = 0;
        m_drop = 0;
        m_hdr = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_rdy", in_rdy, 1);
        base = wr_count;
        build_pkt(8'b0100_0000, 8'hFF, 1, 5, 8'h20);
        send_pkt();
        wait_drain();
        chk("post_rst_writes", wr_count - base, 7);
        chk("post_rst_fwd", pkt_fwd_cnt, 1);
        check_counters("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioq_dst_demux.md
# ioq_dst_demux

Output-side consumer of the destination-port module header written by the output-port-lookup stage. It sits between the lookup stage and the per-port output queues. It buffers each incoming packet, reads the IOQ module header word, and extracts the destination-port bitmap. It then forwards the whole packet, headers included, to every port set in the bitmap. Packets with an empty bitmap or a missing IOQ header are dropped and counted.

## Interface
- DATA_WIDTH, 64, datapath width
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width
- NUM_OUTPUT_QUEUES, 8, number of output ports; bitmap width
- FIFO_DEPTH_BITS, 4, input FIFO depth log2
- CNT_WIDTH, 32, statistics counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- in_data  in  DATA_WIDTH  input word
- in_ctrl  in  CTRL_WIDTH  input ctrl
- in_wr  in  1  write strobe
- in_rdy  out  1  low when the input FIFO is nearly full
- out_data  out  DATA_WIDTH  registered output word, shared by all ports
- out_ctrl  out  CTRL_WIDTH  registered output ctrl
- out_wr  out  NUM_OUTPUT_QUEUES  per-port write strobe
- out_rdy  in  NUM_OUTPUT_QUEUES  per-port ready
- pkt_fwd_cnt  out  CNT_WIDTH  packets forwarded
- pkt_drop_cnt  out  CNT_WIDTH  packets dropped because the bitmap is zero
- hdr_err_cnt  out  CNT_WIDTH  packets whose first word is not the IOQ header

## Operation
- The input FIFO is written with {in_ctrl, in_data} whenever in_wr is high.
- The first word of a packet must have ctrl == IO_QUEUE_STAGE_NUM (8'hFF). The destination bitmap is data[IOQ_DST_PORT_POS+NUM_OUTPUT_QUEUES-1 : IOQ_DST_PORT_POS], with IOQ_DST_PORT_POS = 16.
- State machine, one-hot. Reset state is WAIT_HDR.
  - **WAIT_HDR**: when the FIFO is not empty, examine the head word without popping it.
    - If ctrl != 8'hFF: increment hdr_err_cnt and go to DROP.
    - Else if bitmap == 0: increment pkt_drop_cnt and go to DROP.
    - Else: latch the bitmap into dst_sel and go to SEND_HDRS.
  - **SEND_HDRS**: a word moves when the FIFO is not empty and (out_rdy & dst_sel) == dst_sel.
    - Moving a word pops it and drives out_wr = dst_sel on the next cycle.
    - When a word with ctrl == 0 moves, go to SEND_DATA.
  - **SEND_DATA**: same transfer rule. The first word with ctrl != 0 is EOP.
    - Transfer the EOP word, increment pkt_fwd_cnt, clear dst_sel, and go to WAIT_HDR.
  - **DROP**: pop one word per cycle while the FIFO is not empty. Nothing is written to the outputs.
    - Track the header/data phase the same way as the send states.
    - After popping the EOP word, go to WAIT_HDR.
- Multicast is all-or-nothing: a word is held until every selected port is ready. Ports outside dst_sel are never written.
- The IOQ header word is forwarded unmodified.
- Counters wrap modulo 2^CNT_WIDTH.

## Timing
- Reset values:
  - out_wr = 0, out_data = 0, out_ctrl = 0.
  - All counters = 0, dst_sel = 0, state = WAIT_HDR, FIFO empty.
  - in_rdy = 1 one cycle after reset deasserts.
- Reset asserted mid-packet discards the FIFO contents and the partial packet. No further out_wr pulses are produced.
- Latency: a word written on in_wr at cycle N can appear on out_* no earlier than N+3.
  - N+1: the word is visible at the FIFO head.
  - N+2: header decision in WAIT_HDR.
  - N+3: the transfer decision registers the output.
  - Body words stream at 1 word/cycle while the selected ports are ready.
- out_rdy is sampled in the decision cycle and the write occurs on the following cycle. Downstream FIFOs must provide at least 1 word of slack, which the nearly-full convention on ready guarantees.
- out_wr is asserted for exactly one cycle per transferred word.
- FIFO empty mid-packet: stall with no out_wr and the state held.
- FIFO full: in_rdy is already low at nearly-full, so upstream must not write. A write while full is a protocol violation; behaviour is undefined.
- Back-to-back packets: WAIT_HDR follows the EOP transfer with zero idle cycles, so the next header is decided in the cycle after EOP.
- A counter increment and a wrap in the same cycle is allowed; the counter becomes 0.

## Structure
- Shared package/defines: IO_QUEUE_STAGE_NUM, IOQ_DST_PORT_POS, and the state encodings.
- One sub-module: the existing small_fifo, instantiated as the input buffer, with WIDTH = DATA_WIDTH+CTRL_WIDTH and MAX_DEPTH_BITS = FIFO_DEPTH_BITS.
- The FSM, output register, and counters live in the top level.

## Test plan
- Unicast:
  - Stimulus: header 0xFF with bitmap 8'b0000_0100, one more 0xFF header, 6 data words (ctrl 0), EOP ctrl 0x04, all out_rdy = 1.
  - Required: out_wr = 8'b0000_0100 on all 9 words in order, with data unchanged; pkt_fwd_cnt = 1.
- Multicast with backpressure:
  - Stimulus: bitmap 8'b0101_0001, and port 6 out_rdy held low for 5 cycles mid-packet.
  - Required: no out_wr on any port during the stall; afterwards every word goes out with out_wr = 8'b0101_0001.
- Zero bitmap:
  - Stimulus: a 10-word packet with bitmap 0, followed by a unicast packet to port 1.
  - Required: no writes for the first packet; pkt_drop_cnt = 1; the second packet is forwarded intact.
- Missing IOQ header:
  - Stimulus: the first word has ctrl 0x02.
  - Required: the whole packet is dropped; hdr_err_cnt = 1; the FSM is back in WAIT_HDR.
- Back-to-back with FIFO pressure:
  - Stimulus: 4 packets sent continuously while out_rdy toggles every cycle.
  - Required: in_rdy deasserts at nearly-full; there are no word losses or duplicates; pkt_fwd_cnt = 4.
- Reset mid-packet:
  - Stimulus: assert reset after 3 words have been forwarded.
  - Required: outputs and counters become 0 immediately; a following clean packet is forwarded correctly.
